// File: rtl/i2c_slave_regs_pkg.sv
// i2c_slave_regs_pkg: state encoding and bus constants shared by the I2C target
package i2c_slave_regs_pkg;
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP
  } state_t;
  localparam logic ACK   = 1'b0;
  localparam logic NACK  = 1'b1;
  localparam logic WRITE = 1'b0;
  localparam logic READ  = 1'b1;
  function automatic logic is_ack_phase(state_t s);
    return s inside {ADDR_ACK, PTR_ACK, WDATA_ACK, RACK};
  endfunction
endpackage

// File: rtl/i2c_slave_sync.sv
// i2c_slave_sync: scl/sda synchroniser with edge, START and STOP detection
module i2c_slave_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);
  logic [SYNC_STAGES-1:0] scl_q, sda_q;
  logic scl_h, sda_h, scl_s;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      scl_q <= '1;
      sda_q <= '1;
      scl_h <= 1'b1;
      sda_h <= 1'b1;
    end else begin
      scl_q <= {scl_q[SYNC_STAGES-2:0], scl};
      sda_q <= {sda_q[SYNC_STAGES-2:0], sda};
      scl_h <= scl_s;
      sda_h <= sda_s;
    end
  assign scl_s    = scl_q[SYNC_STAGES-1];
  assign sda_s    = sda_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_h;
  assign scl_fall = ~scl_s & scl_h;
  assign start    = scl_s & scl_h & sda_h & ~sda_s;
  assign stop     = scl_s & scl_h & ~sda_h & sda_s;
endmodule

// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs: register-mapped I2C target with auto-incrementing pointer
module i2c_slave_regs
  import i2c_slave_regs_pkg::*;
#(
  parameter logic [6:0] DEV_ID      = 7'h48,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wr_data,
  output logic       reg_wr_en,
  output logic       reg_rd_req,
  input  logic [7:0] reg_rd_data,
  output logic       busy,
  output logic       bus_err
);
  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [7:0] shreg, sh_n, addr_n, wdat_n, byte_in;
  logic wr_n, rd_n, busy_n, err_n, sda_o, sda_n, rw, rw_n, rd_lat;
  logic sda_s, scl_rise, scl_fall, start, stop, shifting, last, mid_byte;

  i2c_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .scl(scl), .sda(sda),
    .sda_s(sda_s), .scl_rise(scl_rise), .scl_fall(scl_fall), .start(start), .stop(stop)
  );

  assign sda      = sda_o ? 1'bz : 1'b0;
  assign byte_in  = {shreg[6:0], sda_s};
  assign shifting = state inside {ADDR, PTR, WDATA, RDATA};
  assign last     = cnt == 3'd7;
  // the SCL rise that frames a START/STOP has already been counted as a bit
  assign mid_byte = cnt > 3'd1;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = rd_lat ? reg_rd_data : shreg;
    addr_n  = reg_wr_en ? reg_addr + 8'd1 : reg_addr;
    wdat_n  = reg_wr_data;
    wr_n    = 1'b0;
    rd_n    = 1'b0;
    busy_n  = busy;
    err_n   = 1'b0;
    sda_n   = sda_o;
    rw_n    = rw;
    if (start) begin
      state_n = ADDR;
      cnt_n   = 3'd0;
      sda_n   = 1'b1;
      err_n   = !(state inside {IDLE, WAIT_STOP}) && !is_ack_phase(state) && mid_byte;
    end else if (stop) begin
      state_n = IDLE;
      cnt_n   = 3'd0;
      sda_n   = 1'b1;
      busy_n  = 1'b0;
      err_n   = mid_byte;
    end else if (scl_rise) begin
      if (shifting) begin
        sh_n  = byte_in;
        cnt_n = cnt + 3'd1;
      end
      case (state)
        ADDR: if (last) begin
          state_n = byte_in[7:1] == DEV_ID ? ADDR_ACK : WAIT_STOP;
          busy_n  = byte_in[7:1] == DEV_ID;
          rw_n    = byte_in[0];
        end
        PTR: if (last) begin
          addr_n  = byte_in;
          state_n = PTR_ACK;
        end
        WDATA: if (last) begin
          wr_n    = 1'b1;
          wdat_n  = byte_in;
          state_n = WDATA_ACK;
        end
        RDATA: state_n = last ? RACK : RDATA;
        ADDR_ACK: rd_n = rw == READ;
        RACK: begin
          state_n = sda_s == NACK ? WAIT_STOP : RDATA;
          rd_n    = sda_s == ACK;
          addr_n  = sda_s == ACK ? reg_addr + 8'd1 : reg_addr;
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      // in an ACK phase a released SDA means the ACK bit has not started yet
      if (state inside {ADDR_ACK, PTR_ACK, WDATA_ACK}) begin
        if (sda_o) sda_n = ACK;
        else begin
          state_n = state == ADDR_ACK ? (rw == WRITE ? PTR : RDATA) : WDATA;
          sda_n   = state == ADDR_ACK && rw == READ ? shreg[7] : 1'b1;
        end
      end else if (state == RDATA) sda_n = shreg[7];
      else if (state == RACK) sda_n = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      shreg       <= 8'd0;
      reg_addr    <= 8'd0;
      reg_wr_data <= 8'd0;
      reg_wr_en   <= 1'b0;
      reg_rd_req  <= 1'b0;
      busy        <= 1'b0;
      bus_err     <= 1'b0;
      sda_o       <= 1'b1;
      rw          <= WRITE;
      rd_lat      <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      shreg       <= sh_n;
      reg_addr    <= addr_n;
      reg_wr_data <= wdat_n;
      reg_wr_en   <= wr_n;
      reg_rd_req  <= rd_n;
      busy        <= busy_n;
      bus_err     <= err_n;
      sda_o       <= sda_n;
      rw          <= rw_n;
      rd_lat      <= reg_rd_req;
    end
endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb_i2c_slave_regs: bit-banged I2C master with write/read scoreboards
module tb_i2c_slave_regs;
  logic sys_clk = 1'b0, sys_rst_n = 1'b0, scl = 1'b1, m_low = 1'b0;
  wire sda;
  logic [7:0] reg_addr, reg_wr_data, reg_rd_data;
  logic reg_wr_en, reg_rd_req, busy, bus_err;
  logic [7:0] mem [256];
  int checks = 0, errors = 0;
  int dut_low_cnt = 0, err_pulses = 0, both_cnt = 0;
  logic [15:0] obs_wr[$], exp_wr[$];
  logic [7:0] obs_rd[$], exp_rd[$];

  typedef struct {
    logic [7:0] dev, ptr, d0, d1;
    logic acked;
  } wvec_t;
  wvec_t vec [5];

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);
  assign reg_rd_data = mem[reg_addr];
  always #5 sys_clk = ~sys_clk;

  i2c_slave_regs dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .scl(scl), .sda(sda),
    .reg_addr(reg_addr), .reg_wr_data(reg_wr_data), .reg_wr_en(reg_wr_en),
    .reg_rd_req(reg_rd_req), .reg_rd_data(reg_rd_data), .busy(busy), .bus_err(bus_err)
  );

  always @(negedge sys_clk) begin
    if (reg_wr_en) obs_wr.push_back({reg_addr, reg_wr_data});
    if (reg_rd_req) obs_rd.push_back(reg_addr);
    if (bus_err) err_pulses++;
    if (reg_wr_en && reg_rd_req) both_cnt++;
    if (!m_low && sda === 1'b0) dut_low_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    repeat (8) @(posedge sys_clk);
    #1;
  endtask

  task automatic i2c_start();
    m_low = 1'b0; tick();
    scl = 1'b1; tick();
    m_low = 1'b1; tick();
    scl = 1'b0; tick();
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; tick();
    scl = 1'b1; tick();
    m_low = 1'b0; tick();
  endtask

  task automatic bit_out(input logic b);
    m_low = !b; tick();
    scl = 1'b1; tick(); tick();
    scl = 1'b0; tick();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    m_low = 1'b0; tick();
    scl = 1'b1; tick();
    ack = sda;
    tick();
    scl = 1'b0; tick();
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      m_low = 1'b0; tick();
      scl = 1'b1; tick();
      b[i] = sda;
      tick();
      scl = 1'b0; tick();
    end
    bit_out(mack);
  endtask

  task automatic drain(input string tag);
    chk({tag, "_wr_count"}, obs_wr.size(), exp_wr.size());
    while (exp_wr.size() > 0 && obs_wr.size() > 0) chk({tag, "_wr"}, obs_wr.pop_front(), exp_wr.pop_front());
    chk({tag, "_rd_count"}, obs_rd.size(), exp_rd.size());
    while (exp_rd.size() > 0 && obs_rd.size() > 0) chk({tag, "_rd"}, obs_rd.pop_front(), exp_rd.pop_front());
    exp_wr.delete(); obs_wr.delete(); exp_rd.delete(); obs_rd.delete();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic a;
    logic [7:0] b, nxt;
    int e0, l0;
    vec[0] = '{8'h90, 8'h05, 8'hA1, 8'hB2, 1'b1};
    vec[1] = '{8'h92, 8'h00, 8'h33, 8'h44, 1'b0};
    vec[2] = '{8'h90, 8'hFF, 8'h11, 8'h22, 1'b1};
    vec[3] = '{8'h90, 8'h7F, 8'h00, 8'hFF, 1'b1};
    vec[4] = '{8'h20, 8'h01, 8'h55, 8'h66, 1'b0};
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'hA5);
    mem[5] = 8'h3C;
    mem[6] = 8'h7E;
    #23;
    chk("rst_sda", sda, 1'b1);
    chk("rst_outputs", {reg_addr, reg_wr_data, reg_wr_en, reg_rd_req, busy, bus_err}, 0);
    sys_rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      e0 = err_pulses;
      l0 = dut_low_cnt;
      nxt = vec[i].ptr + 8'd1;
      if (vec[i].acked) begin
        exp_wr.push_back({vec[i].ptr, vec[i].d0});
        exp_wr.push_back({nxt, vec[i].d1});
      end
      i2c_start();
      send_byte(vec[i].dev, a); chk($sformatf("v%0d_ack_addr", i), a, !vec[i].acked);
      chk($sformatf("v%0d_busy", i), busy, vec[i].acked);
      send_byte(vec[i].ptr, a); chk($sformatf("v%0d_ack_ptr", i), a, !vec[i].acked);
      send_byte(vec[i].d0, a); chk($sformatf("v%0d_ack_d0", i), a, !vec[i].acked);
      send_byte(vec[i].d1, a); chk($sformatf("v%0d_ack_d1", i), a, !vec[i].acked);
      i2c_stop();
      tick();
      chk($sformatf("v%0d_busy_after_stop", i), busy, 1'b0);
      chk($sformatf("v%0d_bus_err", i), err_pulses - e0, 0);
      if (!vec[i].acked) chk($sformatf("v%0d_sda_untouched", i), dut_low_cnt - l0, 0);
      drain($sformatf("v%0d", i));
    end

    e0 = err_pulses;
    exp_rd.push_back(8'h05);
    exp_rd.push_back(8'h06);
    i2c_start();
    send_byte(8'h90, a); chk("rd_ack_addr_w", a, 1'b0);
    send_byte(8'h05, a); chk("rd_ack_ptr", a, 1'b0);
    i2c_start();
    send_byte(8'h91, a); chk("rd_ack_addr_r", a, 1'b0);
    recv_byte(1'b0, b); chk("rd_byte0", b, 8'h3C);
    recv_byte(1'b1, b); chk("rd_byte1", b, 8'h7E);
    chk("rd_released_after_nack", sda, 1'b1);
    tick();
    chk("rd_released_later", sda, 1'b1);
    i2c_stop();
    tick();
    chk("rd_busy_after_stop", busy, 1'b0);
    chk("rd_bus_err", err_pulses - e0, 0);
    drain("rd");

    e0 = err_pulses;
    i2c_start();
    send_byte(8'h90, a); chk("ab_ack_addr", a, 1'b0);
    send_byte(8'h10, a); chk("ab_ack_ptr", a, 1'b0);
    bit_out(1'b1); bit_out(1'b0); bit_out(1'b1);
    i2c_stop();
    tick();
    chk("ab_bus_err_pulses", err_pulses - e0, 1);
    chk("ab_busy", busy, 1'b0);
    drain("ab");
    e0 = err_pulses;
    exp_wr.push_back({8'h20, 8'h5A});
    i2c_start();
    send_byte(8'h90, a); chk("ab2_ack_addr", a, 1'b0);
    send_byte(8'h20, a); chk("ab2_ack_ptr", a, 1'b0);
    send_byte(8'h5A, a); chk("ab2_ack_data", a, 1'b0);
    i2c_stop();
    tick();
    chk("ab2_bus_err", err_pulses - e0, 0);
    drain("ab2");

    exp_rd.push_back(8'h05);
    i2c_start();
    send_byte(8'h90, a);
    send_byte(8'h05, a);
    i2c_start();
    send_byte(8'h91, a); chk("rr_ack_addr", a, 1'b0);
    chk("rr_target_drives_0", sda, 1'b0);
    #3 sys_rst_n = 1'b0;
    #1;
    chk("rr_sda_released", sda, 1'b1);
    chk("rr_outputs", {reg_addr, reg_wr_data, reg_wr_en, reg_rd_req, busy, bus_err}, 0);
    scl = 1'b1;
    m_low = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    tick();
    chk("rr_busy_after", busy, 1'b0);
    drain("rr");

    chk("wr_rd_overlap", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
